// File: rtl/galetron_pkg.sv
// Shared Galetron definitions: opcodes and the default program-counter type.
package galetron_pkg;

    localparam int unsigned PC_WIDTH_DEF = 12;
    localparam int unsigned OP_WIDTH     = 6;

    localparam logic [OP_WIDTH-1:0] OP_CALL = 6'b010111;
    localparam logic [OP_WIDTH-1:0] OP_RET  = 6'b011000;

    typedef logic [PC_WIDTH_DEF-1:0] pc_t;

endpackage : galetron_pkg

// File: rtl/ras_storage.sv
// Return-address storage: DEPTH x PC_WIDTH registers, one synchronous write
// port and one asynchronous read port (driven with sp-1 by the owner).
module ras_storage #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PC_WIDTH = 12,
    parameter int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [PC_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [PC_WIDTH-1:0] rd_data_o
);

    logic [PC_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are not reset since stale entries are never read
    // without a prior push.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Asynchronous read of the top-of-stack entry.
    always_comb begin
        rd_data_o = mem_q[rd_addr_i];
    end

endmodule : ras_storage

// File: rtl/return_address_stack.sv
// Circular return-address stack: a call pushes program_counter+1, a return
// pops the most recent address as a jump target one cycle later.
module return_address_stack
    import galetron_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [5:0]          operation,
    input  logic [PC_WIDTH-1:0] program_counter,
    output logic [PC_WIDTH-1:0] return_address,
    output logic                return_valid,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned SP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [SP_W-1:0]     sp_q,    sp_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PC_WIDTH-1:0] ra_q,    ra_d;
    logic                rv_q,    rv_d;
    logic                ovf_q,   ovf_d;
    logic                und_q,   und_d;

    logic                is_call_c;
    logic                is_ret_c;
    logic                push_c;
    logic [SP_W-1:0]     top_idx_c;
    logic [PC_WIDTH-1:0] link_addr_c;
    logic [PC_WIDTH-1:0] top_data_c;

    // Opcode decode and derived push address (wraps at PC_WIDTH).
    always_comb begin
        is_call_c   = enable && (operation == OP_CALL);
        is_ret_c    = enable && (operation == OP_RET);
        push_c      = reset && is_call_c;
        top_idx_c   = sp_q - SP_W'(1);
        link_addr_c = program_counter + PC_WIDTH'(1);
    end

    ras_storage #(
        .DEPTH    (DEPTH),
        .PC_WIDTH (PC_WIDTH),
        .ADDR_W   (SP_W)
    ) u_storage (
        .clock     (clock),
        .wr_en_i   (push_c),
        .wr_addr_i (sp_q),
        .wr_data_i (link_addr_c),
        .rd_addr_i (top_idx_c),
        .rd_data_o (top_data_c)
    );

    // Status decoded from the registered occupancy count.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_FULL);
    end

    // Next-state for pointer, count, return port and sticky flags.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        ra_d    = ra_q;
        rv_d    = 1'b0;
        ovf_d   = ovf_q;
        und_d   = und_q;

        if (is_call_c) begin
            sp_d = sp_q + SP_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (is_ret_c) begin
            if (empty) begin
                ra_d  = '0;
                und_d = 1'b1;
            end else begin
                ra_d    = top_data_c;
                sp_d    = top_idx_c;
                count_d = count_q - CNT_W'(1);
                rv_d    = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sp_q    <= '0;
            count_q <= '0;
            ra_q    <= '0;
            rv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ra_q    <= ra_d;
            rv_q    <= rv_d;
            ovf_q   <= ovf_d;
            und_q   <= und_d;
        end
    end

    // Registered outputs.
    always_comb begin
        return_address = ra_q;
        return_valid   = rv_q;
        overflow       = ovf_q;
        underflow      = und_q;
    end

endmodule : return_address_stack

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack: a queue-based reference model
// predicts pops; a monitor checks each return_valid pulse against it.
module tb_return_address_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PCW   = 12;
    localparam logic [5:0] CALL = 6'b010111;
    localparam logic [5:0] RET  = 6'b011000;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic [5:0]     operation;
    logic [PCW-1:0] program_counter;
    logic [PCW-1:0] return_address;
    logic           return_valid;
    logic           empty, full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PCW-1:0] m_stack[$];
    logic [PCW-1:0] m_ra;
    logic           m_rv, m_ovf, m_und;
    logic [PCW-1:0] sb[$];

    return_address_stack #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .operation       (operation),
        .program_counter (program_counter),
        .return_address  (return_address),
        .return_valid    (return_valid),
        .empty           (empty),
        .full            (full),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input logic rst, input logic en, input logic [5:0] op,
                        input logic [PCW-1:0] pc);
        reset = rst; enable = en; operation = op; program_counter = pc;
        if (!rst) begin
            m_stack.delete();
            m_ra = '0; m_rv = 1'b0; m_ovf = 1'b0; m_und = 1'b0;
        end else if (en && op == CALL) begin
            m_stack.push_back(PCW'(pc + 1));
            if (m_stack.size() > DEPTH) begin
                void'(m_stack.pop_front());
                m_ovf = 1'b1;
            end
            m_rv = 1'b0;
        end else if (en && op == RET) begin
            if (m_stack.size() > 0) begin
                m_ra = m_stack.pop_back();
                m_rv = 1'b1;
                sb.push_back(m_ra);
            end else begin
                m_ra = '0; m_rv = 1'b0; m_und = 1'b1;
            end
        end else begin
            m_rv = 1'b0;
        end
        @(posedge clock);
        #1;
        chk("empty",          32'(empty),          32'(m_stack.size() == 0));
        chk("full",           32'(full),           32'(m_stack.size() == DEPTH));
        chk("overflow",       32'(overflow),       32'(m_ovf));
        chk("underflow",      32'(underflow),      32'(m_und));
        chk("return_valid",   32'(return_valid),   32'(m_rv));
        chk("return_address", 32'(return_address), 32'(m_ra));
    endtask

    // Monitor: every valid pulse must match the oldest outstanding prediction.
    initial begin
        forever begin
            @(negedge clock);
            if (return_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected at %0t: got %0h expected no pulse", $time, return_address);
                end else begin
                    chk("sb_data", 32'(return_address), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        int r;
        reset = 1'b0; enable = 1'b0; operation = '0; program_counter = '0;
        m_ra = '0; m_rv = 1'b0; m_ovf = 1'b0; m_und = 1'b0;
        step(1'b0, 1'b0, 6'h00, 12'h000);
        step(1'b0, 1'b1, RET,   12'h000);
        // Idle opcodes after reset
        step(1'b1, 1'b1, 6'h00, 12'h123);
        step(1'b1, 1'b1, 6'h3F, 12'h456);

        // Push/push/pop/pop
        step(1'b1, 1'b1, CALL, 12'h010);
        step(1'b1, 1'b1, CALL, 12'h020);
        step(1'b1, 1'b1, RET,  12'h000);
        step(1'b1, 1'b1, RET,  12'h000);
        step(1'b1, 1'b1, 6'h00, 12'h000);

        // PC wrap-around
        step(1'b1, 1'b1, CALL, 12'hFFF);
        step(1'b1, 1'b1, RET,  12'h000);

        // Overflow then drain into underflow
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, CALL, PCW'(12'h100 + i));
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, RET, 12'h000);

        // Underflow on empty, then push/pop
        step(1'b0, 1'b0, 6'h00, 12'h000);
        step(1'b1, 1'b1, RET,  12'h000);
        step(1'b1, 1'b1, CALL, 12'h040);
        step(1'b1, 1'b1, RET,  12'h000);

        // Stall after a pop, then reset during a pop
        step(1'b0, 1'b0, 6'h00, 12'h000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, CALL, PCW'(12'h200 + 16 * i));
        step(1'b1, 1'b1, RET,  12'h000);
        step(1'b1, 1'b0, RET,  12'h000);
        step(1'b1, 1'b0, RET,  12'h000);
        step(1'b0, 1'b1, RET,  12'h000);
        step(1'b1, 1'b1, RET,  12'h000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 7) != 0),
                 (r < 45) ? CALL : (r < 90) ? RET : 6'($urandom_range(0, 63)),
                 PCW'($urandom));
        end

        // Drain scoreboard, bounded
        step(1'b1, 1'b0, 6'h00, 12'h000);
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_return_address_stack
